// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg -- shared declarations for the fetch-address sequencer.
//
// Contents:
//   pc_state_e             : sequencer state (BOOT after reset, RUN otherwise)
//   PC_ADDR_W_DEFAULT      : default fetch-address width
//   PC_EXC_VECTOR_DEFAULT  : default exception vector (32-bit, truncated by
//                            the sequencer to its own ADDR_W)
//   pc_addr_t              : fetch address at the default width
//   pc_step                : modulo-2^W address increment helper
//
// A package cannot take parameters, so pc_addr_t is fixed at the default
// width; modules built with another ADDR_W declare logic [ADDR_W-1:0].
// ---------------------------------------------------------------------------
package pc_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } pc_state_e;

    localparam int          PC_ADDR_W_DEFAULT     = 32;
    localparam logic [31:0] PC_EXC_VECTOR_DEFAULT = 32'h0000_0020;

    typedef logic [PC_ADDR_W_DEFAULT-1:0] pc_addr_t;

    // Address increment; overflow wraps silently at all-ones.
    function automatic pc_addr_t pc_step(input pc_addr_t addr, input pc_addr_t step);
        return addr + step;
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// ---------------------------------------------------------------------------
// pc_redirect_buf -- single-entry branch/jump target buffer.
//
// Holds one redirect target that could not be applied yet (the fetch was
// stalled). A newer load overwrites the stored target; clear empties it.
// Load takes priority over clear.
//
// Ports:
//   clk        in   clock
//   srst       in   synchronous active-high reset (empties the buffer)
//   load       in   store load_addr and mark pending
//   load_addr  in   target to store
//   clear      in   drop the buffered target
//   pending    out  a target is buffered
//   target     out  buffered target (meaningful only while pending)
// ---------------------------------------------------------------------------
module pc_redirect_buf #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              clear,
    output logic              pending,
    output logic [ADDR_W-1:0] target
);

    logic              pending_reg;
    logic [ADDR_W-1:0] target_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            pending_reg <= 1'b0;
            target_reg  <= '0;
        end else if (load) begin
            pending_reg <= 1'b1;
            target_reg  <= load_addr;
        end else if (clear) begin
            pending_reg <= 1'b0;
        end
    end

    assign pending = pending_reg;
    assign target  = target_reg;

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer -- fetch-address sequencer (program counter) for the MIPS core.
//
// Holds the current fetch address, advances it by STEP on each accepted
// fetch, applies branch/jump redirects (buffering one across stalls) and
// vectors to EXC_VECTOR on an exception while capturing EPC.
//
// Parameters:
//   ADDR_W      address width in bits
//   STEP        increment per sequential advance
//   RESET_ADDR  cur_addr after reset
//   EXC_VECTOR  exception target, truncated to ADDR_W
//
// Ports:
//   clk               in   clock, all state updates on rising edge
//   reset             in   synchronous active-high reset
//   stall             in   hazard stall, blocks sequential/redirect advance
//   fetch_ready       in   instruction memory accepts cur_addr this cycle
//   fetch_valid       out  cur_addr is a valid fetch request
//   cur_addr          out  current fetch address
//   next_addr         out  registered cur_addr + STEP
//   redirect_valid    in   branch/jump taken this cycle
//   redirect_addr     in   redirect target
//   redirect_pending  out  a redirect target is buffered, not yet applied
//   exc_valid         in   exception: flush and vector (ignored in BOOT)
//   epc               out  cur_addr captured at the last exception
//   in_delay_slot     out  cur_addr is a branch delay slot
//                          (port exists only with PC_DELAY_SLOT_EN)
//
// Build option PC_DELAY_SLOT_EN: a redirect taken on an advance first steps
// into the delay slot (cur_addr + STEP) and jumps on the following advance.
// ---------------------------------------------------------------------------
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               ADDR_W     = 32,
    parameter int               STEP       = 1,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter logic [31:0]      EXC_VECTOR = PC_EXC_VECTOR_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              fetch_ready,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [ADDR_W-1:0] next_addr,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              redirect_pending,
    input  logic              exc_valid,
    output logic [ADDR_W-1:0] epc
`ifdef PC_DELAY_SLOT_EN
    ,
    output logic              in_delay_slot
`endif
);

    localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] EXC_A  = ADDR_W'(EXC_VECTOR);

    pc_state_e         state_reg;
    logic              fetch_valid_reg;
    logic [ADDR_W-1:0] cur_addr_reg;
    logic [ADDR_W-1:0] cur_addr_next;
    logic [ADDR_W-1:0] next_addr_reg;
    logic [ADDR_W-1:0] epc_reg;

    logic              advance;
    logic              exc_take;

    logic              buf_load;
    logic              buf_clear;
    logic              buf_pending;
    logic [ADDR_W-1:0] buf_target;

`ifdef PC_DELAY_SLOT_EN
    logic              slot_reg;
    logic              slot_next;
`endif

    // fetch_valid_reg always equals (state_reg == RUN); it is kept as its
    // own flop so the output comes straight from a register.
    assign advance  = fetch_valid_reg & fetch_ready & ~stall;
    assign exc_take = exc_valid & (state_reg == RUN);

    // -----------------------------------------------------------------------
    // Next-address selection: exception > redirect (buffered or incoming)
    // > sequential.
    // -----------------------------------------------------------------------
    always_comb begin
        cur_addr_next = cur_addr_reg;
        buf_load      = 1'b0;
        buf_clear     = 1'b0;
`ifdef PC_DELAY_SLOT_EN
        slot_next     = slot_reg;
`endif

        if (exc_take) begin
            // Flush: any buffered target (and a delay slot) is discarded.
            cur_addr_next = EXC_A;
            buf_clear     = 1'b1;
`ifdef PC_DELAY_SLOT_EN
            slot_next     = 1'b0;
`endif
        end else begin
`ifdef PC_DELAY_SLOT_EN
            if (slot_reg) begin
                // Sitting on the slot: redirects are ignored, the next
                // accepted fetch jumps to the target latched on entry.
                if (advance) begin
                    cur_addr_next = buf_target;
                    buf_clear     = 1'b1;
                    slot_next     = 1'b0;
                end
            end else if (advance && (redirect_valid || buf_pending)) begin
                // Step into the delay slot. A newly arriving target replaces
                // any buffered one; otherwise the buffered target is kept.
                cur_addr_next = cur_addr_reg + STEP_A;
                buf_load      = redirect_valid;
                slot_next     = 1'b1;
            end else if (redirect_valid) begin
                buf_load = 1'b1;
            end else if (advance) begin
                cur_addr_next = cur_addr_reg + STEP_A;
            end
`else
            if (advance && redirect_valid) begin
                // Incoming target wins over anything buffered.
                cur_addr_next = redirect_addr;
                buf_clear     = 1'b1;
            end else if (redirect_valid) begin
                buf_load = 1'b1;
            end else if (advance && buf_pending) begin
                cur_addr_next = buf_target;
                buf_clear     = 1'b1;
            end else if (advance) begin
                cur_addr_next = cur_addr_reg + STEP_A;
            end
`endif
        end
    end

    // -----------------------------------------------------------------------
    // State and registered outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= BOOT;
            fetch_valid_reg <= 1'b0;
            cur_addr_reg    <= RESET_ADDR;
            next_addr_reg   <= RESET_ADDR + STEP_A;
            epc_reg         <= '0;
`ifdef PC_DELAY_SLOT_EN
            slot_reg        <= 1'b0;
`endif
        end else begin
            // BOOT lasts exactly one cycle.
            state_reg       <= RUN;
            fetch_valid_reg <= 1'b1;
            cur_addr_reg    <= cur_addr_next;
            // Tracks cur_addr every cycle, so it only moves when cur_addr does.
            next_addr_reg   <= cur_addr_next + STEP_A;
            if (exc_take) begin
                epc_reg <= cur_addr_reg;
            end
`ifdef PC_DELAY_SLOT_EN
            slot_reg        <= slot_next;
`endif
        end
    end

    pc_redirect_buf #(
        .ADDR_W (ADDR_W)
    ) u_redirect_buf (
        .clk       (clk),
        .srst      (reset),
        .load      (buf_load),
        .load_addr (redirect_addr),
        .clear     (buf_clear),
        .pending   (buf_pending),
        .target    (buf_target)
    );

    assign fetch_valid      = fetch_valid_reg;
    assign cur_addr         = cur_addr_reg;
    assign next_addr        = next_addr_reg;
    assign epc              = epc_reg;
    assign redirect_pending = buf_pending;
`ifdef PC_DELAY_SLOT_EN
    assign in_delay_slot    = slot_reg;
`endif

endmodule
